// File: rtl/vfc_pkg.sv
// Shared definitions for the video frame checker: FSM encoding, register
// map, CRC constants and field widths.
package vfc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } vfc_state_t;

  localparam logic [5:0] ADDR_CTRL   = 6'h00;
  localparam logic [5:0] ADDR_STATUS = 6'h04;
  localparam logic [5:0] ADDR_CRC    = 6'h08;
  localparam logic [5:0] ADDR_PIXCNT = 6'h0C;
  localparam logic [5:0] ADDR_TIMING = 6'h10;
  localparam logic [5:0] ADDR_EXPECT = 6'h14;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  localparam int HCNT_W = 12;
  localparam int LINE_W = 11;
  localparam int PIX_W  = 20;
  localparam int RGB_W  = 6;

  localparam logic [HCNT_W-1:0] HCNT_MAX = '1;
  localparam logic [PIX_W-1:0]  PIX_MAX  = '1;

endpackage

// File: rtl/vfc_crc16_step.sv
// One pixel worth of CRC-16-CCITT: shifts six rgb bits in, bit 5 first.
module vfc_crc16_step
  import vfc_pkg::*;
(
  input  logic [15:0]      crc_in,
  input  logic [RGB_W-1:0] data6,
  output logic [15:0]      crc_out
);

  // Bit-serial CRC unrolled over the six pixel bits, MSB first.
  always_comb begin
    crc_out = crc_in;
    for (int i = RGB_W - 1; i >= 0; i--) begin
      if (crc_out[15] ^ data6[i]) crc_out = {crc_out[14:0], 1'b0} ^ CRC_POLY;
      else                        crc_out = {crc_out[14:0], 1'b0};
    end
  end

endmodule

// File: rtl/tqvp_video_frame_checker.sv
// Passive video frame checker on the TinyQV peripheral bus. Recovers
// line/frame timing from {vsync, hsync, rgb}, and signs one armed frame
// with CRC-16, lit-pixel count, line period and line count.
// Optional build macro VFC_EXPECT_EN adds an EXPECT register, a match flag
// and interrupt-on-fail.
//
// Bus handshake: the register bus never stalls. A write takes effect on the
// clock edge where data_write_n != 2'b11; data_out is combinational on
// address, and data_ready is constantly 1.
module tqvp_video_frame_checker
  import vfc_pkg::*;
#(
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int H_START   = 296,
  parameter int H_ACTIVE  = 1024,
  parameter int V_START   = 35,
  parameter int V_ACTIVE  = 768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  vid_in,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam logic [HCNT_W-1:0] H_LO = HCNT_W'(H_START);
  localparam logic [HCNT_W-1:0] H_HI = HCNT_W'(H_START + H_ACTIVE);
  localparam logic [LINE_W-1:0] V_LO = LINE_W'(V_START);
  localparam logic [LINE_W-1:0] V_HI = LINE_W'(V_START + V_ACTIVE);

  logic [7:0]        s1;
  logic [1:0]        s2;          // only the sync bits are needed one stage later
  logic              vs1, vs2, hs1, hs2, vs_edge, hs_edge;
  logic [HCNT_W-1:0] h_cnt, hperiod;
  logic [LINE_W-1:0] line_cnt, lines;
  logic              in_window;
  vfc_state_t        state, state_next;
  logic              wr, ctrl_wr, arm, abort, clr_done, start, finish, busy;
  logic [15:0]       crc_acc, crc_next, crc_res;
  logic [PIX_W-1:0]  pix_acc, pix_res;
  logic              done, ovf, irq_en;
  logic [15:0]       expect_val;
  logic              match, valid;
  logic              unused_bus;

  assign unused_bus = ^{data_in[31:3], data_read_n};
  assign data_ready = 1'b1;

  // Normalise sync polarity so that 1 always means asserted.
  assign vs1     = s1[7] ^ ~VSYNC_POL;
  assign hs1     = s1[6] ^ ~HSYNC_POL;
  assign vs2     = s2[1] ^ ~VSYNC_POL;
  assign hs2     = s2[0] ^ ~HSYNC_POL;
  assign vs_edge = vs1 & ~vs2;
  assign hs_edge = hs1 & ~hs2;

  assign in_window = (h_cnt >= H_LO) && (h_cnt < H_HI) &&
                     (line_cnt >= V_LO) && (line_cnt < V_HI);

  assign wr       = (data_write_n != 2'b11);
  assign ctrl_wr  = wr && (address == ADDR_CTRL);
  assign arm      = ctrl_wr && data_in[0];
  assign abort    = ctrl_wr && data_in[2];
  assign clr_done = wr && (address == ADDR_STATUS) && data_in[2];
  assign busy     = (state == ST_WAIT_VS) || (state == ST_CAPTURE);
  assign start    = arm && !abort && ((state == ST_IDLE) || (state == ST_DONE));
  assign finish   = !abort && (state == ST_CAPTURE) && vs_edge;

  // Input sampling pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= vid_in;
      s2 <= s1[7:6];
    end
  end

  // Pixel and line position counters; vsync edge beats a coincident hsync edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt    <= '0;
      line_cnt <= '0;
    end else begin
      if (hs_edge)                h_cnt <= '0;
      else if (h_cnt != HCNT_MAX) h_cnt <= h_cnt + 1'b1;
      if (vs_edge)                line_cnt <= '0;
      else if (hs_edge)           line_cnt <= line_cnt + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // FSM next state; abort overrides everything.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (arm)     state_next = ST_WAIT_VS;
      ST_WAIT_VS: if (vs_edge) state_next = ST_CAPTURE;
      ST_CAPTURE: if (vs_edge) state_next = ST_DONE;
      ST_DONE:    if (arm)     state_next = ST_WAIT_VS;
      default:                 state_next = ST_IDLE;
    endcase
    if (abort) state_next = ST_IDLE;
  end

  vfc_crc16_step u_crc (
    .crc_in  (crc_acc),
    .data6   (s1[5:0]),
    .crc_out (crc_next)
  );

  // Signature accumulation, result latching and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_acc <= '0;
      pix_acc <= '0;
      crc_res <= '0;
      pix_res <= '0;
      hperiod <= '0;
      lines   <= '0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      irq_en  <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= data_in[1];
      if (start) begin
        crc_acc <= CRC_INIT;
        pix_acc <= '0;
        lines   <= '0;
        done    <= 1'b0;
        ovf     <= 1'b0;
      end else begin
        if ((h_cnt == HCNT_MAX) && !hs_edge) ovf <= 1'b1;
        if ((state == ST_CAPTURE) && in_window) begin
          crc_acc <= crc_next;
          if ((s1[5:0] != '0) && (pix_acc != PIX_MAX)) pix_acc <= pix_acc + 1'b1;
        end
        if ((state == ST_CAPTURE) && hs_edge) hperiod <= h_cnt + 1'b1;
        if (finish) begin
          crc_res <= crc_acc;
          pix_res <= pix_acc;
          lines   <= line_cnt + 1'b1;
          done    <= 1'b1;
        end else if (clr_done) begin
          done <= 1'b0;
        end
      end
    end
  end

`ifdef VFC_EXPECT_EN
  logic irq_on_fail;

  // Expected-signature register and the match verdict taken on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      expect_val  <= '0;
      irq_on_fail <= 1'b0;
      match       <= 1'b0;
      valid       <= 1'b0;
    end else begin
      if (wr && (address == ADDR_EXPECT)) expect_val <= data_in[15:0];
      if (ctrl_wr) irq_on_fail <= data_in[3];
      if (start) begin
        match <= 1'b0;
        valid <= 1'b0;
      end else if (finish) begin
        match <= (crc_acc == expect_val);
        valid <= 1'b1;
      end
    end
  end

  assign user_interrupt = done & irq_en & (~irq_on_fail | (valid & ~match));
`else
  assign expect_val     = '0;
  assign match          = 1'b0;
  assign valid          = 1'b0;
  assign user_interrupt = done & irq_en;
`endif

  // Register read mux; unmapped addresses read 0.
  always_comb begin
    data_out = '0;
    case (address)
      ADDR_CTRL:   data_out[1:0]  = {irq_en, busy};
      ADDR_STATUS: data_out[5:0]  = {valid, match, ovf, done, state};
      ADDR_CRC:    data_out[15:0] = crc_res;
      ADDR_PIXCNT: data_out[19:0] = pix_res;
      ADDR_TIMING: begin
        data_out[11:0]  = hperiod;
        data_out[26:16] = lines;
      end
      ADDR_EXPECT: data_out[15:0] = expect_val;
      default:     data_out = '0;
    endcase
  end

endmodule
